// File: rtl/alu_req_issuer.sv
// Request-side driver for a combinational ALU: one registered issue stage feeding the
// ALU, an in-order response FIFO capturing its result, and sticky overflow / op-count status.
module alu_req_issuer #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [WIDTH-1:0] req_a_i,
   input  logic [WIDTH-1:0] req_b_i,
   input  logic [3:0]       req_op_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   output logic [3:0]       alu_op_o,
   input  logic [WIDTH-1:0] alu_y_i,
   input  logic [3:0]       alu_flags_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [WIDTH-1:0] rsp_y_o,
   output logic [3:0]       rsp_flags_o,
   output logic [TAG_W-1:0] rsp_tag_o,
   output logic             rsp_err_o,
   input  logic             stat_clr_i,
   output logic             stat_ovf_o,
   output logic [CNT_W-1:0] stat_ops_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] y;
      logic [3:0]       flags;
      logic [TAG_W-1:0] tag;
      logic             err;
   } rsp_t;

   logic             v1_q, v1_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] ops_q, ops_d;
   rsp_t             mem_q [DEPTH];
   rsp_t             head, wdata;
   logic             push, pop, accept, ovf_set;

   assign pop         = rsp_valid_o && rsp_ready_i;
   assign push        = v1_q && ((count_q != CNT_FULL) || pop);
   assign req_ready_o = !v1_q || push;
   assign accept      = req_valid_i && req_ready_o;
   assign ovf_set     = push && alu_flags_i[1];
   assign wdata       = '{y: alu_y_i, flags: alu_flags_i, tag: tag_q, err: (op_q > 4'd1)};

   always_comb begin
      v1_d    = v1_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      tag_d   = tag_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      ops_d   = ops_q;
      // Operands only move on accept so the ALU inputs stay stable while idle.
      if (accept) begin
         v1_d  = 1'b1;
         a_d   = req_a_i;
         b_d   = req_b_i;
         op_d  = req_op_i;
         tag_d = req_tag_i;
      end else if (push) begin
         v1_d = 1'b0;
      end
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (ovf_set)         ovf_d = 1'b1;
      else if (stat_clr_i) ovf_d = 1'b0;
      if (stat_clr_i) ops_d = push ? CNT_W'(1) : '0;
      else if (push)  ops_d = ops_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         v1_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         tag_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         ops_q   <= '0;
      end else begin
         v1_q    <= v1_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         tag_q   <= tag_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         ops_q   <= ops_d;
      end
   end

   // Storage needs no reset: reads are masked whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= wdata;
   end

   assign head        = mem_q[rd_q];
   assign rsp_valid_o = (count_q != '0);
   assign rsp_y_o     = rsp_valid_o ? head.y     : '0;
   assign rsp_flags_o = rsp_valid_o ? head.flags : '0;
   assign rsp_tag_o   = rsp_valid_o ? head.tag   : '0;
   assign rsp_err_o   = rsp_valid_o ? head.err   : 1'b0;

   assign alu_a_o    = a_q;
   assign alu_b_o    = b_q;
   assign alu_op_o   = op_q;
   assign stat_ovf_o = ovf_q;
   assign stat_ops_o = ops_q;
endmodule
